// File: rtl/rob_multi_commit.sv
// Reorder buffer with configurable depth, N result buses, up to two
// in-order commits per cycle, same-cycle result bypass on operand lookup
// and a single-cycle mispredict flush.
module rob_multi_commit #(
    parameter int DEPTH = 16,
    parameter int IDW   = 4,
    parameter int N_CDB = 2,
    parameter int CMT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   alloc_valid,
    input  logic [2:0]             alloc_type,
    input  logic [4:0]             alloc_rd,
    input  logic [31:0]            alloc_prd_pc,
    output logic                   alloc_ready,
    output logic [IDW-1:0]         alloc_id,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*IDW-1:0]   cdb_id,
    input  logic [N_CDB*32-1:0]    cdb_val,
    input  logic [N_CDB*32-1:0]    cdb_rel_pc,
    input  logic                   st_rdy_valid,
    input  logic [IDW-1:0]         st_rdy_id,
    input  logic [IDW-1:0]         src1_id,
    input  logic [IDW-1:0]         src2_id,
    output logic                   src1_ready,
    output logic                   src2_ready,
    output logic [31:0]            src1_val,
    output logic [31:0]            src2_val,
    output logic [CMT_W-1:0]       cmt_rf_valid,
    output logic [CMT_W*5-1:0]     cmt_rf_rd,
    output logic [CMT_W*32-1:0]    cmt_rf_val,
    output logic [CMT_W*IDW-1:0]   cmt_rf_id,
    output logic                   cmt_st_valid,
    output logic [IDW-1:0]         cmt_st_id,
    output logic                   flush_flag,
    output logic [31:0]            flush_pc,
    output logic [IDW-1:0]         head_id,
    output logic [IDW:0]           count
);

    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_BR  = 3'd1;
    localparam logic [2:0] T_JMP = 3'd2;
    localparam logic [2:0] T_LD  = 3'd3;
    localparam logic [2:0] T_ST  = 3'd4;

    localparam logic [IDW:0] FULL_CNT = (IDW+1)'(DEPTH);
    localparam bit           DUAL     = (CMT_W == 2);

    function automatic logic is_branch(input logic [2:0] t);
        return (t == T_BR) || (t == T_JMP);
    endfunction

    function automatic logic writes_rf(input logic [2:0] t);
        return (t == T_ALU) || (t == T_LD) || (t == T_JMP);
    endfunction

    function automatic logic second_slot_ok(input logic [2:0] t);
        return (t == T_ALU) || (t == T_LD);
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [IDW:0]     head, tail;
    logic [DEPTH-1:0] busy, ready;

    logic [2:0]  e_type [DEPTH];
    logic [4:0]  e_rd   [DEPTH];
    logic [31:0] e_prd  [DEPTH];
    logic [31:0] e_val  [DEPTH];
    logic [31:0] e_rel  [DEPTH];

    logic [IDW-1:0] h0, h1, t_idx;
    logic           fire0, fire1, mispredict_now, alloc_fire;
    logic [IDW:0]   n_cmt;

    logic [DEPTH-1:0] cdb_hit, st_hit;
    logic [31:0]      cdb_wval [DEPTH];
    logic [31:0]      cdb_wpc  [DEPTH];

    logic [IDW-1:0] src_id  [2];
    logic           src_rdy [2];
    logic [31:0]    src_v   [2];

    logic           slot_wr  [2];
    logic [IDW-1:0] slot_idx [2];

    assign h0    = head[IDW-1:0];
    assign h1    = h0 + IDW'(1);
    assign t_idx = tail[IDW-1:0];

    assign count    = tail - head;
    assign head_id  = h0;
    assign alloc_id = t_idx;

    // Slot 0 retires a ready head; slot 1 only takes a plain ALU/LD behind a
    // non-store, correctly predicted slot 0.
    assign fire0          = busy[h0] && ready[h0];
    assign mispredict_now = fire0 && is_branch(e_type[h0]) && (e_prd[h0] != e_rel[h0]);
    assign fire1          = DUAL && fire0 && !mispredict_now && (e_type[h0] != T_ST)
                            && busy[h1] && ready[h1] && second_slot_ok(e_type[h1]);
    assign n_cmt          = {{IDW{1'b0}}, fire0} + {{IDW{1'b0}}, fire1};

    // Full blocks allocation outright, so a slot freed by this cycle's commit
    // is not reused until the next cycle.
    assign alloc_ready = (count != FULL_CNT) && !flush_flag && !mispredict_now;
    assign alloc_fire  = rdy && alloc_valid && alloc_ready;

    assign src_id[0]  = src1_id;
    assign src_id[1]  = src2_id;
    assign src1_ready = src_rdy[0];
    assign src2_ready = src_rdy[1];
    assign src1_val   = src_v[0];
    assign src2_val   = src_v[1];

    // Per-entry result-bus decode; scanning high to low lets the lowest channel win.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cdb_hit[i]  = 1'b0;
            cdb_wval[i] = '0;
            cdb_wpc[i]  = '0;
            st_hit[i]   = st_rdy_valid && (st_rdy_id == IDW'(i));
            for (int c = N_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && (cdb_id[c*IDW +: IDW] == IDW'(i))) begin
                    cdb_hit[i]  = 1'b1;
                    cdb_wval[i] = cdb_val[c*32 +: 32];
                    cdb_wpc[i]  = cdb_rel_pc[c*32 +: 32];
                end
            end
        end
    end

    // Operand lookup: stored value first, else bypass from the lowest matching channel.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_rdy[s] = 1'b0;
            src_v[s]   = '0;
            if (busy[src_id[s]]) begin
                if (ready[src_id[s]]) begin
                    src_rdy[s] = 1'b1;
                    src_v[s]   = e_val[src_id[s]];
                end else begin
                    for (int c = N_CDB - 1; c >= 0; c--) begin
                        if (cdb_valid[c] && (cdb_id[c*IDW +: IDW] == src_id[s])) begin
                            src_rdy[s] = 1'b1;
                            src_v[s]   = cdb_val[c*32 +: 32];
                        end
                    end
                end
            end
        end
    end

    // Commit slot descriptors feeding the registered commit outputs.
    always_comb begin
        slot_idx[0] = h0;
        slot_idx[1] = h1;
        slot_wr[0]  = fire0 && writes_rf(e_type[h0]);
        slot_wr[1]  = fire1;
    end

    // Pointer and busy/ready bookkeeping; a mispredict empties the buffer
    // just past the retiring branch and drops this cycle's results.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            busy  <= '0;
            ready <= '0;
        end else if (rdy) begin
            if (mispredict_now) begin
                busy  <= '0;
                ready <= '0;
                head  <= head + (IDW+1)'(1);
                tail  <= head + (IDW+1)'(1);
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i] && (cdb_hit[i] || st_hit[i])) begin
                        ready[i] <= 1'b1;
                    end
                end
                if (fire0) begin
                    busy[h0]  <= 1'b0;
                    ready[h0] <= 1'b0;
                end
                if (fire1) begin
                    busy[h1]  <= 1'b0;
                    ready[h1] <= 1'b0;
                end
                if (alloc_fire) begin
                    busy[t_idx]  <= 1'b1;
                    ready[t_idx] <= 1'b0;
                end
                head <= head + n_cmt;
                tail <= tail + {{IDW{1'b0}}, alloc_fire};
            end
        end
    end

    // Entry payload storage; only meaningful while the entry is busy.
    always_ff @(posedge clk) begin
        if (rdy && !mispredict_now) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && cdb_hit[i]) begin
                    e_val[i] <= cdb_wval[i];
                    if (is_branch(e_type[i])) begin
                        e_rel[i] <= cdb_wpc[i];
                    end
                end
            end
            if (alloc_fire) begin
                e_type[t_idx] <= alloc_type;
                e_rd[t_idx]   <= alloc_rd;
                e_prd[t_idx]  <= alloc_prd_pc;
            end
        end
    end

    // Registered commit/flush outputs, valid for the single cycle after the commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmt_rf_valid <= '0;
            cmt_rf_rd    <= '0;
            cmt_rf_val   <= '0;
            cmt_rf_id    <= '0;
            cmt_st_valid <= 1'b0;
            cmt_st_id    <= '0;
            flush_flag   <= 1'b0;
            flush_pc     <= '0;
        end else if (!rdy) begin
            cmt_rf_valid <= '0;
            cmt_st_valid <= 1'b0;
            flush_flag   <= 1'b0;
        end else begin
            for (int s = 0; s < CMT_W; s++) begin
                cmt_rf_valid[s] <= slot_wr[s];
                if (slot_wr[s]) begin
                    cmt_rf_rd[s*5 +: 5]     <= e_rd[slot_idx[s]];
                    cmt_rf_val[s*32 +: 32]  <= e_val[slot_idx[s]];
                    cmt_rf_id[s*IDW +: IDW] <= slot_idx[s];
                end
            end
            cmt_st_valid <= fire0 && (e_type[h0] == T_ST);
            if (fire0 && (e_type[h0] == T_ST)) begin
                cmt_st_id <= h0;
            end
            flush_flag <= mispredict_now;
            if (mispredict_now) begin
                flush_pc <= e_rel[h0];
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Scoreboard bench for rob_multi_commit: directed stimulus pushes expected
// commit/flush events; a negedge monitor pops and compares them.
module tb_rob_multi_commit;

    localparam int DEPTH = 16;
    localparam int IDW   = 4;
    localparam int N_CDB = 2;
    localparam int CMT_W = 2;

    localparam logic [2:0] T_ALU = 3'd0;
    localparam logic [2:0] T_BR  = 3'd1;
    localparam logic [2:0] T_ST  = 3'd4;

    logic                 clk, rst, rdy;
    logic                 alloc_valid;
    logic [2:0]           alloc_type;
    logic [4:0]           alloc_rd;
    logic [31:0]          alloc_prd_pc;
    logic                 alloc_ready;
    logic [IDW-1:0]       alloc_id;
    logic [N_CDB-1:0]     cdb_valid;
    logic [N_CDB*IDW-1:0] cdb_id;
    logic [N_CDB*32-1:0]  cdb_val;
    logic [N_CDB*32-1:0]  cdb_rel_pc;
    logic                 st_rdy_valid;
    logic [IDW-1:0]       st_rdy_id;
    logic [IDW-1:0]       src1_id, src2_id;
    logic                 src1_ready, src2_ready;
    logic [31:0]          src1_val, src2_val;
    logic [CMT_W-1:0]     cmt_rf_valid;
    logic [CMT_W*5-1:0]   cmt_rf_rd;
    logic [CMT_W*32-1:0]  cmt_rf_val;
    logic [CMT_W*IDW-1:0] cmt_rf_id;
    logic                 cmt_st_valid;
    logic [IDW-1:0]       cmt_st_id;
    logic                 flush_flag;
    logic [31:0]          flush_pc;
    logic [IDW-1:0]       head_id;
    logic [IDW:0]         count;

    rob_multi_commit #(.DEPTH(DEPTH), .IDW(IDW), .N_CDB(N_CDB), .CMT_W(CMT_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
        .alloc_prd_pc(alloc_prd_pc), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
        .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .cdb_rel_pc(cdb_rel_pc),
        .st_rdy_valid(st_rdy_valid), .st_rdy_id(st_rdy_id),
        .src1_id(src1_id), .src2_id(src2_id),
        .src1_ready(src1_ready), .src2_ready(src2_ready),
        .src1_val(src1_val), .src2_val(src2_val),
        .cmt_rf_valid(cmt_rf_valid), .cmt_rf_rd(cmt_rf_rd), .cmt_rf_val(cmt_rf_val),
        .cmt_rf_id(cmt_rf_id), .cmt_st_valid(cmt_st_valid), .cmt_st_id(cmt_st_id),
        .flush_flag(flush_flag), .flush_pc(flush_pc), .head_id(head_id), .count(count)
    );

    typedef struct {
        logic [1:0]  rfv;
        logic [4:0]  rd0, rd1;
        logic [31:0] v0, v1;
        logic [3:0]  id0, id1;
        logic        st;
        logic [3:0]  stid;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.rfv = 2'b00; e.rd0 = '0; e.rd1 = '0; e.v0 = '0; e.v1 = '0;
        e.id0 = '0; e.id1 = '0; e.st = 1'b0; e.stid = '0; e.fl = 1'b0; e.fpc = '0;
        return e;
    endfunction

    task automatic push_rf1(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] id);
        exp_t e;
        e = blank();
        e.rfv = 2'b01; e.rd0 = rd; e.v0 = v; e.id0 = id;
        exp_q.push_back(e);
    endtask

    task automatic push_rf2(input logic [4:0] rda, input logic [31:0] va, input logic [3:0] ida,
                            input logic [4:0] rdb, input logic [31:0] vb, input logic [3:0] idb);
        exp_t e;
        e = blank();
        e.rfv = 2'b11; e.rd0 = rda; e.v0 = va; e.id0 = ida;
        e.rd1 = rdb; e.v1 = vb; e.id1 = idb;
        exp_q.push_back(e);
    endtask

    task automatic push_st(input logic [3:0] id);
        exp_t e;
        e = blank();
        e.st = 1'b1; e.stid = id;
        exp_q.push_back(e);
    endtask

    task automatic push_fl(input logic [31:0] pc);
        exp_t e;
        e = blank();
        e.fl = 1'b1; e.fpc = pc;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle that shows a commit or flush consumes one expected event.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && (cmt_rf_valid != '0 || cmt_st_valid || flush_flag)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: rf_valid=%b st_valid=%b flush=%b, expected no output",
                         cmt_rf_valid, cmt_st_valid, flush_flag);
            end else begin
                e = exp_q.pop_front();
                chk("rf_valid", 32'(cmt_rf_valid), 32'(e.rfv));
                if (e.rfv[0]) begin
                    chk("slot0_rd", 32'(cmt_rf_rd[4:0]), 32'(e.rd0));
                    chk("slot0_val", cmt_rf_val[31:0], e.v0);
                    chk("slot0_id", 32'(cmt_rf_id[3:0]), 32'(e.id0));
                end
                if (e.rfv[1]) begin
                    chk("slot1_rd", 32'(cmt_rf_rd[9:5]), 32'(e.rd1));
                    chk("slot1_val", cmt_rf_val[63:32], e.v1);
                    chk("slot1_id", 32'(cmt_rf_id[7:4]), 32'(e.id1));
                end
                chk("st_valid", 32'(cmt_st_valid), 32'(e.st));
                if (e.st) chk("st_id", 32'(cmt_st_id), 32'(e.stid));
                chk("flush_flag", 32'(flush_flag), 32'(e.fl));
                if (e.fl) chk("flush_pc", flush_pc, e.fpc);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cdb_valid    = '0;
        cdb_id       = '0;
        cdb_val      = '0;
        cdb_rel_pc   = '0;
        st_rdy_valid = 1'b0;
        st_rdy_id    = '0;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] id, input logic [31:0] v,
                           input logic [31:0] pc);
        cdb_valid[ch]            = 1'b1;
        cdb_id[ch*IDW +: IDW]    = id;
        cdb_val[ch*32 +: 32]     = v;
        cdb_rel_pc[ch*32 +: 32]  = pc;
    endtask

    task automatic do_alloc(input logic [2:0] t, input logic [4:0] rd, input logic [31:0] pc);
        alloc_valid  = 1'b1;
        alloc_type   = t;
        alloc_rd     = rd;
        alloc_prd_pc = pc;
        cyc();
        alloc_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_type = '0; alloc_rd = '0; alloc_prd_pc = '0;
        src1_id = '0; src2_id = '0;
        idle();
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_id", 32'(alloc_id), 0);
        chk("rst_head_id", 32'(head_id), 0);
        chk("rst_rf_valid", 32'(cmt_rf_valid), 0);
        chk("rst_rf_val", cmt_rf_val[31:0], 0);
        chk("rst_st_valid", 32'(cmt_st_valid), 0);
        chk("rst_flush", 32'(flush_flag), 0);
        chk("rst_flush_pc", flush_pc, 0);

        // Three ALU ops, results arrive youngest first, then dual + single commit.
        for (int k = 0; k < 3; k++) begin
            alloc_valid = 1'b1; alloc_type = T_ALU; alloc_rd = 5'(k + 1); alloc_prd_pc = '0;
            #1 chk("t1_alloc_id", 32'(alloc_id), k);
            cyc();
        end
        alloc_valid = 1'b0;
        #1 chk("t1_count3", 32'(count), 3);
        push_rf2(5'd1, 32'h30, 4'd0, 5'd2, 32'h20, 4'd1);
        push_rf1(5'd3, 32'h10, 4'd2);
        set_cdb(0, 4'd2, 32'h10, 0); cyc(); idle();
        set_cdb(0, 4'd1, 32'h20, 0); cyc(); idle();
        set_cdb(0, 4'd0, 32'h30, 0); cyc(); idle();
        repeat (3) cyc();
        chk("t1_count0", 32'(count), 0);

        // Fill all 16 entries starting at index 3; alloc_id wraps 15 -> 0.
        for (int k = 0; k < 16; k++) begin
            alloc_valid = 1'b1; alloc_type = T_ALU;
            alloc_rd = 5'(((3 + k) % 16) + 1); alloc_prd_pc = '0;
            #1;
            chk("t2_alloc_id", 32'(alloc_id), (3 + k) % 16);
            chk("t2_alloc_ready", 32'(alloc_ready), 1);
            cyc();
        end
        #1;
        chk("t2_full_ready", 32'(alloc_ready), 0);
        chk("t2_full_count", 32'(count), 16);
        cyc();
        alloc_valid = 1'b0;
        #1;
        chk("t2_full_held", 32'(count), 16);
        chk("t2_full_alloc_id", 32'(alloc_id), 3);
        push_rf1(5'd4, 32'h55, 4'd3);
        set_cdb(0, 4'd3, 32'h55, 0); cyc(); idle();
        #1 chk("t2_ready_before", 32'(alloc_ready), 0);
        cyc();
        #1;
        chk("t2_ready_after", 32'(alloc_ready), 1);
        chk("t2_count15", 32'(count), 15);
        // Drain: results written youngest first so the rest commits in pairs.
        for (int p = 0; p < 7; p++) begin
            push_rf2(5'(((4 + 2*p) % 16) + 1), 32'h100 + ((4 + 2*p) % 16), 4'((4 + 2*p) % 16),
                     5'(((5 + 2*p) % 16) + 1), 32'h100 + ((5 + 2*p) % 16), 4'((5 + 2*p) % 16));
        end
        push_rf1(5'd3, 32'h102, 4'd2);
        for (int k = 14; k >= 0; k--) begin
            set_cdb(0, 4'((4 + k) % 16), 32'h100 + ((4 + k) % 16), 0);
            cyc();
            idle();
        end
        repeat (10) cyc();
        chk("t2_drained", 32'(count), 0);

        // Reset in the middle of operation.
        alloc_valid = 1'b1; alloc_type = T_ALU; alloc_rd = 5'd20;
        repeat (2) cyc();
        alloc_valid = 1'b0;
        #1 chk("rst2_pre_count", 32'(count), 2);
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst2_count", 32'(count), 0);
        chk("rst2_alloc_id", 32'(alloc_id), 0);

        // Mispredicted branch at head with a ready ALU behind it.
        do_alloc(T_BR, 5'd0, 32'h100);
        do_alloc(T_ALU, 5'd7, 32'h0);
        push_fl(32'h200);
        set_cdb(0, 4'd0, 32'h0, 32'h200);
        set_cdb(1, 4'd1, 32'h77, 32'h0);
        cyc(); idle();
        #1 chk("t3_mispredict_blocks", 32'(alloc_ready), 0);
        cyc();
        #1;
        chk("t3_flush_flag", 32'(flush_flag), 1);
        chk("t3_flush_pc", flush_pc, 32'h200);
        chk("t3_count", 32'(count), 0);
        chk("t3_alloc_id", 32'(alloc_id), 1);
        chk("t3_flush_blocks", 32'(alloc_ready), 0);
        cyc();
        #1;
        chk("t3_flush_pulse", 32'(flush_flag), 0);
        chk("t3_ready_again", 32'(alloc_ready), 1);

        // Store at head with ALU behind: store alone, then the ALU.
        do_alloc(T_ST, 5'd0, 32'h0);
        do_alloc(T_ALU, 5'd9, 32'h0);
        push_st(4'd1);
        push_rf1(5'd9, 32'h99, 4'd2);
        st_rdy_valid = 1'b1; st_rdy_id = 4'd1;
        set_cdb(0, 4'd2, 32'h99, 0);
        cyc(); idle();
        repeat (4) cyc();
        chk("t4a_count", 32'(count), 0);

        // ALU at head with store behind: store is never taken in slot 1.
        do_alloc(T_ALU, 5'd10, 32'h0);
        do_alloc(T_ST, 5'd0, 32'h0);
        push_rf1(5'd10, 32'h3A, 4'd3);
        push_st(4'd4);
        st_rdy_valid = 1'b1; st_rdy_id = 4'd4;
        set_cdb(0, 4'd3, 32'h3A, 0);
        cyc(); idle();
        repeat (4) cyc();
        chk("t4b_count", 32'(count), 0);

        // Two channels hit id 5 in one cycle; lowest channel wins for bypass and storage.
        alloc_valid = 1'b1; alloc_type = T_ALU; alloc_rd = 5'd11;
        #1 chk("t5_alloc_id", 32'(alloc_id), 5);
        cyc();
        alloc_valid = 1'b0;
        src1_id = 4'd5; src2_id = 4'd6;
        #1 chk("t5_not_ready", 32'(src1_ready), 0);
        push_rf1(5'd11, 32'hAA, 4'd5);
        set_cdb(0, 4'd5, 32'hAA, 0);
        set_cdb(1, 4'd5, 32'hBB, 0);
        #1;
        chk("t5_bypass_ready", 32'(src1_ready), 1);
        chk("t5_bypass_val", src1_val, 32'hAA);
        chk("t5_nonbusy_ready", 32'(src2_ready), 0);
        cyc(); idle();
        #1;
        chk("t5_stored_ready", 32'(src1_ready), 1);
        chk("t5_stored_val", src1_val, 32'hAA);
        cyc();

        // rdy low for three cycles with a ready head: nothing moves.
        alloc_valid = 1'b1; alloc_type = T_ALU; alloc_rd = 5'd12;
        #1 chk("t6_alloc_id", 32'(alloc_id), 6);
        cyc();
        alloc_valid = 1'b0;
        push_rf1(5'd12, 32'hCC, 4'd6);
        set_cdb(0, 4'd6, 32'hCC, 0);
        cyc(); idle();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_frozen_count", 32'(count), 1);
            chk("t6_frozen_rf_valid", 32'(cmt_rf_valid), 0);
            chk("t6_frozen_head", 32'(head_id), 6);
        end
        rdy = 1'b1;
        cyc();
        chk("t6_count_after", 32'(count), 0);

        repeat (3) cyc();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
